mac_pe_os_mk2: RTL and testbench

- Next-generation output-stationary systolic PE.
- Each cycle it accumulates a LANES-wide dot product of forwarded activation/weight vectors.
- Multiplier pipeline depth is configurable; signed/unsigned operands and wrap/saturating accumulation are selectable at runtime.
- A double-buffered drain register is chained down the PE column, so results are shifted out while the next tile accumulates.

---
 rtl/mac_os_pkg.sv | 34 +++
 rtl/mac_pe_os_mk2_mul.sv | 38 +++
 rtl/mac_pe_os_mk2.sv | 158 +++++++++++++++
 tb/tb_mac_pe_os_mk2.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_os_pkg.sv
// Shared widths, saturation limits and accumulate-mode encoding for the
// output-stationary MAC processing element.
package mac_os_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    ACC_WRAP = 1'b0,
    ACC_SAT  = 1'b1
  } acc_mode_e;

  function automatic int clog2_w(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Operands are widened by one bit so signed and unsigned share one multiplier.
  function automatic int prod_w(input int ip_w);
    return 2 * ip_w + 2;
  endfunction

  function automatic int sum_w(input int ip_w, input int lanes);
    return prod_w(ip_w) + clog2_w(lanes);
  endfunction

  // Upper (hi=1) or lower (hi=0) representable accumulator value.
  function automatic logic signed [MAX_W+1:0] sat_limit(input int op_w, input logic uns,
                                                       input logic hi);
    logic signed [MAX_W+1:0] one;
    one = (MAX_W + 2)'(1);
    if (uns) return hi ? (one <<< op_w) - one : '0;
    return hi ? (one <<< (op_w - 1)) - one : -(one <<< (op_w - 1));
  endfunction

endpackage

// File: rtl/mac_pe_os_mk2_mul.sv
// One lane: operand extension, signed multiply and MUL_STAGES product
// registers; products of invalid beats enter the pipe as zero.
module mac_lane_mul_pipe
  import mac_os_pkg::*;
#(
  parameter int IP_W       = 8,
  parameter int MUL_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld,
  input  logic                           uns,
  input  logic [IP_W-1:0]                x,
  input  logic [IP_W-1:0]                w,
  output logic signed [prod_w(IP_W)-1:0] prod
);

  localparam int PW = prod_w(IP_W);

  logic signed [PW-1:0] xe, we, prod_c;
  logic signed [PW-1:0] pipe [MUL_STAGES];

  assign xe     = PW'($signed({~uns & x[IP_W-1], x}));
  assign we     = PW'($signed({~uns & w[IP_W-1], w}));
  assign prod_c = xe * we;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= vld ? prod_c : '0;
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign prod = pipe[MUL_STAGES-1];

endmodule

// File: rtl/mac_pe_os_mk2.sv
// Output-stationary systolic PE: LANES-wide dot product per beat, wrap or
// saturating accumulate, and a chained drain register for finished tiles.
module mac_pe_os_mk2
  import mac_os_pkg::*;
#(
  parameter int IP_W           = 8,
  parameter int LANES          = 1,
  parameter int OP_W           = 48,
  parameter int MUL_STAGES     = 2,
  parameter int CLR_LOAD_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_in,
  input  logic                  clr_in,
  output logic                  en_out,
  output logic                  clr_out,
  input  logic [LANES*IP_W-1:0] x_in,
  input  logic [LANES*IP_W-1:0] w_in,
  output logic [LANES*IP_W-1:0] x_out,
  output logic [LANES*IP_W-1:0] w_out,
  input  logic                  uns_mode,
  input  logic                  sat_mode,
  output logic [OP_W-1:0]       mac_out,
  output logic                  ovf,
  input  logic                  shift_en,
  input  logic                  dr_vld_in,
  input  logic [OP_W-1:0]       dr_data_in,
  output logic                  dr_vld_out,
  output logic [OP_W-1:0]       dr_data_out,
  output logic                  dr_err
);

  localparam int PW = prod_w(IP_W);
  localparam int SW = sum_w(IP_W, LANES);
  localparam int TW = OP_W + 2;

  // en_in is a pure valid strobe: every beat presented with en_in=1 is taken,
  // there is no ready/backpressure path.
  logic [LANES*IP_W-1:0] x_s1, w_s1;
  logic                  en_s1, clr_s1;
  logic                  vld_p [MUL_STAGES];
  logic                  clr_p [MUL_STAGES];
  logic signed [PW-1:0]  lane_p [LANES];
  logic                  vld_a, clr_a;
  logic signed [SW-1:0]  lane_sum;
  logic signed [TW-1:0]  sum_ext, acc_ext, t, lim_hi, lim_lo;
  logic                  ovf_now, capture;
  logic [OP_W-1:0]       acc, acc_nxt, dr_data;
  logic                  ovf_q, seen_clr, dr_vld, dr_err_q;
  acc_mode_e             mode;

  // S1 doubles as the neighbour forwarding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_s1   <= '0;
      w_s1   <= '0;
      en_s1  <= 1'b0;
      clr_s1 <= 1'b0;
    end else begin
      x_s1   <= x_in;
      w_s1   <= w_in;
      en_s1  <= en_in;
      clr_s1 <= en_in & clr_in;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_lane_mul_pipe #(
      .IP_W      (IP_W),
      .MUL_STAGES(MUL_STAGES)
    ) u_mul (
      .clk (clk),
      .rst (rst),
      .vld (en_s1),
      .uns (uns_mode),
      .x   (x_s1[k*IP_W +: IP_W]),
      .w   (w_s1[k*IP_W +: IP_W]),
      .prod(lane_p[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        vld_p[i] <= 1'b0;
        clr_p[i] <= 1'b0;
      end
    end else begin
      vld_p[0] <= en_s1;
      clr_p[0] <= clr_s1;
      for (int i = 1; i < MUL_STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        clr_p[i] <= clr_p[i-1];
      end
    end
  end

  assign vld_a   = vld_p[MUL_STAGES-1];
  assign clr_a   = clr_p[MUL_STAGES-1];
  assign mode    = sat_mode ? ACC_SAT : ACC_WRAP;
  assign capture = vld_a & clr_a & seen_clr;

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) lane_sum = lane_sum + SW'(lane_p[k]);
  end

  // t carries two guard bits so it holds acc+sum exactly in either mode.
  always_comb begin
    sum_ext = TW'(lane_sum);
    acc_ext = uns_mode ? {2'b00, acc} : {{2{acc[OP_W-1]}}, acc};
    lim_hi  = TW'(sat_limit(OP_W, uns_mode, 1'b1));
    lim_lo  = TW'(sat_limit(OP_W, uns_mode, 1'b0));
    if (clr_a) t = (CLR_LOAD_FIRST != 0) ? sum_ext : '0;
    else       t = acc_ext + sum_ext;
    ovf_now = (t > lim_hi) || (t < lim_lo);
    acc_nxt = t[OP_W-1:0];
    if (ovf_now && mode == ACC_SAT) acc_nxt = (t > lim_hi) ? lim_hi[OP_W-1:0] : lim_lo[OP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      ovf_q    <= 1'b0;
      seen_clr <= 1'b0;
      dr_data  <= '0;
      dr_vld   <= 1'b0;
      dr_err_q <= 1'b0;
    end else begin
      if (vld_a) begin
        acc   <= acc_nxt;
        ovf_q <= clr_a ? ovf_now : (ovf_q | ovf_now);
        if (clr_a) seen_clr <= 1'b1;
      end
      // A capture beats a shift; losing upstream data or an unread result is an error.
      if (capture) begin
        dr_data <= acc;
        dr_vld  <= 1'b1;
        if (shift_en || dr_vld) dr_err_q <= 1'b1;
      end else if (shift_en) begin
        dr_data <= dr_data_in;
        dr_vld  <= dr_vld_in;
      end
    end
  end

  assign en_out      = en_s1;
  assign clr_out     = clr_s1;
  assign x_out       = x_s1;
  assign w_out       = w_s1;
  assign mac_out     = acc;
  assign ovf         = ovf_q;
  assign dr_vld_out  = dr_vld;
  assign dr_data_out = dr_data;
  assign dr_err      = dr_err_q;

endmodule

// File: tb/tb_mac_pe_os_mk2.sv
// Directed bench: default PE with a downstream drain neighbour, a 4-lane PE
// and an 18-bit accumulator PE, all checked against hand-computed values.
module tb_mac_pe_os_mk2;

  logic clk, rst, uns, sat, shift_en, drv_vld;
  logic [47:0] drv_data;
  int n_tests, n_fail;

  logic       en_a, clr_a;
  logic [7:0] x_a, w_a, x_out_a, w_out_a;
  logic       en_out_a, clr_out_a, ovf_a, dr_vld_a, dr_err_a;
  logic [47:0] mac_a, dr_data_a;

  logic [7:0]  x_out_d, w_out_d;
  logic        en_out_d, clr_out_d, ovf_d, dr_vld_d, dr_err_d;
  logic [47:0] mac_d, dr_data_d;

  logic        en_b, clr_b;
  logic [31:0] x_b, w_b, x_out_b, w_out_b;
  logic        en_out_b, clr_out_b, ovf_b, dr_vld_b, dr_err_b;
  logic [47:0] mac_b, dr_data_b;

  logic        en_c, clr_c;
  logic [7:0]  x_c, w_c, x_out_c, w_out_c;
  logic        en_out_c, clr_out_c, ovf_c, dr_vld_c, dr_err_c;
  logic [17:0] mac_c, dr_data_c;

  mac_pe_os_mk2 u_dut (
    .clk(clk), .rst(rst), .en_in(en_a), .clr_in(clr_a), .en_out(en_out_a), .clr_out(clr_out_a),
    .x_in(x_a), .w_in(w_a), .x_out(x_out_a), .w_out(w_out_a), .uns_mode(uns), .sat_mode(sat),
    .mac_out(mac_a), .ovf(ovf_a), .shift_en(shift_en), .dr_vld_in(drv_vld), .dr_data_in(drv_data),
    .dr_vld_out(dr_vld_a), .dr_data_out(dr_data_a), .dr_err(dr_err_a));

  mac_pe_os_mk2 u_dn (
    .clk(clk), .rst(rst), .en_in(1'b0), .clr_in(1'b0), .en_out(en_out_d), .clr_out(clr_out_d),
    .x_in(8'd0), .w_in(8'd0), .x_out(x_out_d), .w_out(w_out_d), .uns_mode(uns), .sat_mode(sat),
    .mac_out(mac_d), .ovf(ovf_d), .shift_en(shift_en), .dr_vld_in(dr_vld_a), .dr_data_in(dr_data_a),
    .dr_vld_out(dr_vld_d), .dr_data_out(dr_data_d), .dr_err(dr_err_d));

  mac_pe_os_mk2 #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .en_in(en_b), .clr_in(clr_b), .en_out(en_out_b), .clr_out(clr_out_b),
    .x_in(x_b), .w_in(w_b), .x_out(x_out_b), .w_out(w_out_b), .uns_mode(uns), .sat_mode(sat),
    .mac_out(mac_b), .ovf(ovf_b), .shift_en(shift_en), .dr_vld_in(1'b0), .dr_data_in(48'd0),
    .dr_vld_out(dr_vld_b), .dr_data_out(dr_data_b), .dr_err(dr_err_b));

  mac_pe_os_mk2 #(.OP_W(18)) u_w18 (
    .clk(clk), .rst(rst), .en_in(en_c), .clr_in(clr_c), .en_out(en_out_c), .clr_out(clr_out_c),
    .x_in(x_c), .w_in(w_c), .x_out(x_out_c), .w_out(w_out_c), .uns_mode(uns), .sat_mode(sat),
    .mac_out(mac_c), .ovf(ovf_c), .shift_en(shift_en), .dr_vld_in(1'b0), .dr_data_in(18'd0),
    .dr_vld_out(dr_vld_c), .dr_data_out(dr_data_c), .dr_err(dr_err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat_a(input logic c, input logic [7:0] x, input logic [7:0] w);
    @(negedge clk);
    en_a = 1'b1; clr_a = c; x_a = x; w_a = w;
  endtask

  task automatic stop_a();
    @(negedge clk);
    en_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic beat_b(input logic c, input logic [31:0] x, input logic [31:0] w);
    @(negedge clk);
    en_b = 1'b1; clr_b = c; x_b = x; w_b = w;
  endtask

  task automatic stop_b();
    @(negedge clk);
    en_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic beat_c(input logic c, input logic [7:0] x, input logic [7:0] w);
    @(negedge clk);
    en_c = 1'b1; clr_c = c; x_c = x; w_c = w;
  endtask

  task automatic stop_c();
    @(negedge clk);
    en_c = 1'b0; clr_c = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; uns = 1'b0; sat = 1'b0; shift_en = 1'b0; drv_vld = 1'b0; drv_data = '0;
    en_a = 0; clr_a = 0; x_a = '0; w_a = '0;
    en_b = 0; clr_b = 0; x_b = '0; w_b = '0;
    en_c = 0; clr_c = 0; x_c = '0; w_c = '0;
    wait_neg(2);
    rst = 1'b0;

    check("rst_mac", longint'(mac_a), 0);
    check("rst_ovf", longint'(ovf_a), 0);
    check("rst_dr_vld", longint'(dr_vld_a), 0);
    check("rst_dr_err", longint'(dr_err_a), 0);
    check("rst_en_out", longint'(en_out_a), 0);
    check("rst_mac_l4", longint'(mac_b), 0);
    check("rst_mac_w18", longint'(mac_c), 0);

    // Signed dot products, back to back, clr on the first beat.
    beat_a(1'b1, 8'sd3, 8'sd4);
    beat_a(1'b0, -8'sd2, 8'sd5);
    beat_a(1'b0, 8'sd7, -8'sd1);
    beat_a(1'b0, 8'sd1, 8'sd1);
    check("lat_mac_still_0", longint'($signed(mac_a)), 0);
    check("fwd_x_out", longint'($signed(x_out_a)), 7);
    check("fwd_w_out", longint'($signed(w_out_a)), -1);
    check("fwd_en_out", longint'(en_out_a), 1);
    check("fwd_clr_out", longint'(clr_out_a), 0);
    stop_a();
    check("t1_beat1", longint'($signed(mac_a)), 12);
    wait_neg(1);
    check("t1_beat2", longint'($signed(mac_a)), 2);
    wait_neg(1);
    check("t1_beat3", longint'($signed(mac_a)), -5);
    wait_neg(1);
    check("t1_beat4", longint'($signed(mac_a)), -4);
    check("t1_ovf", longint'(ovf_a), 0);
    check("t1_first_clr_no_capture", longint'(dr_vld_a), 0);

    // Second tile captures the first tile's -4.
    beat_a(1'b1, 8'sd10, 8'sd10);
    stop_a();
    wait_neg(3);
    check("t2_mac", longint'($signed(mac_a)), 100);
    check("t2_dr_data", longint'($signed(dr_data_a)), -4);
    check("t2_dr_vld", longint'(dr_vld_a), 1);
    shift_en = 1'b1; drv_vld = 1'b0; drv_data = '0;
    wait_neg(1);
    shift_en = 1'b0;
    check("t2_shift_vld", longint'(dr_vld_a), 0);
    check("t2_dn_data", longint'($signed(dr_data_d)), -4);

    // Third tile: capture 100, then shift it downstream.
    beat_a(1'b1, 8'sd2, 8'sd3);
    stop_a();
    wait_neg(3);
    check("t3_mac", longint'($signed(mac_a)), 6);
    check("t3_dr_data", longint'($signed(dr_data_a)), 100);
    check("t3_dr_vld", longint'(dr_vld_a), 1);
    check("t3_dr_err", longint'(dr_err_a), 0);
    shift_en = 1'b1;
    wait_neg(1);
    shift_en = 1'b0;
    check("t3_shift_vld", longint'(dr_vld_a), 0);
    check("t3_dn_data", longint'($signed(dr_data_d)), 100);
    check("t3_dn_vld", longint'(dr_vld_d), 1);
    check("t3_dn_err", longint'(dr_err_d), 0);

    // Capture in the same cycle as a shift.
    beat_a(1'b1, 8'sd1, 8'sd1);
    stop_a();
    wait_neg(2);
    shift_en = 1'b1; drv_vld = 1'b1; drv_data = 48'd77;
    wait_neg(1);
    shift_en = 1'b0;
    check("col_dr_data", longint'($signed(dr_data_a)), 6);
    check("col_dr_vld", longint'(dr_vld_a), 1);
    check("col_dr_err", longint'(dr_err_a), 1);
    check("col_mac", longint'($signed(mac_a)), 1);
    shift_en = 1'b1;
    wait_neg(1);
    shift_en = 1'b0; drv_vld = 1'b0; drv_data = '0;
    check("col_shift_data", longint'($signed(dr_data_a)), 77);
    wait_neg(3);
    check("col_err_sticky", longint'(dr_err_a), 1);

    // Reset with three beats in flight.
    beat_a(1'b0, 8'sd5, 8'sd5);
    beat_a(1'b0, 8'sd5, 8'sd5);
    beat_a(1'b0, 8'sd5, 8'sd5);
    stop_a();
    rst = 1'b1;
    wait_neg(1);
    rst = 1'b0;
    check("mrst_mac", longint'(mac_a), 0);
    check("mrst_ovf", longint'(ovf_a), 0);
    check("mrst_en_out", longint'(en_out_a), 0);
    check("mrst_clr_out", longint'(clr_out_a), 0);
    check("mrst_x_out", longint'(x_out_a), 0);
    check("mrst_w_out", longint'(w_out_a), 0);
    check("mrst_dr_vld", longint'(dr_vld_a), 0);
    check("mrst_dr_data", longint'(dr_data_a), 0);
    check("mrst_dr_err", longint'(dr_err_a), 0);
    for (int i = 0; i < 4; i++) begin
      wait_neg(1);
      check("mrst_no_commit", longint'(mac_a), 0);
    end
    beat_a(1'b1, 8'sd3, 8'sd4);
    beat_a(1'b0, 8'sd2, 8'sd2);
    stop_a();
    wait_neg(2);
    check("mrst_resume1", longint'($signed(mac_a)), 12);
    wait_neg(1);
    check("mrst_resume2", longint'($signed(mac_a)), 16);
    check("mrst_no_capture", longint'(dr_vld_a), 0);

    // Four unsigned lanes at full scale.
    uns = 1'b1;
    beat_b(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    stop_b();
    wait_neg(3);
    check("l4_mac", longint'(mac_b), 260100);
    check("l4_ovf", longint'(ovf_b), 0);
    uns = 1'b0;

    // 18-bit accumulator, saturating.
    sat = 1'b1;
    for (int i = 0; i < 9; i++) beat_c(i == 0, 8'sd127, 8'sd127);
    stop_c();
    wait_neg(2);
    check("sat_beat8", longint'($signed(mac_c)), 129032);
    check("sat_beat8_ovf", longint'(ovf_c), 0);
    wait_neg(1);
    check("sat_clamp", longint'($signed(mac_c)), 131071);
    check("sat_ovf", longint'(ovf_c), 1);

    // Same stimulus, wrapping; the clr beat clears the sticky flag.
    sat = 1'b0;
    for (int i = 0; i < 9; i++) begin
      beat_c(i == 0, 8'sd127, 8'sd127);
      if (i == 4) begin
        check("wrap_first", longint'($signed(mac_c)), 16129);
        check("wrap_ovf_cleared", longint'(ovf_c), 0);
      end
    end
    stop_c();
    wait_neg(2);
    check("wrap_beat8", longint'($signed(mac_c)), 129032);
    wait_neg(1);
    check("wrap_value", longint'($signed(mac_c)), -116983);
    check("wrap_ovf", longint'(ovf_c), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
